// File: rtl/multiply_controller_if.sv
// Handshake and multiplier-side bus for multiply_controller.
// master: the controller (drives o_*); slave: the surrounding system (drives i_*).
//   i_valid/o_ready              operand pair handshake, i_multiplicand/i_multiplier (N)
//   o_valid/i_ready              result handshake, o_product (2N)
//   o_error                      sticky timeout flag
//   o_mul_start, o_mul_*         start pulse and operands to the multiplier (N)
//   i_mul_finished, i_mul_product finished strobe and product from the multiplier (2N)
interface multiply_controller_if #(
    parameter int unsigned N = 8
);
    logic               i_valid;
    logic               o_ready;
    logic [N-1:0]       i_multiplicand;
    logic [N-1:0]       i_multiplier;
    logic               o_valid;
    logic               i_ready;
    logic [2*N-1:0]     o_product;
    logic               o_error;
    logic               o_mul_start;
    logic [N-1:0]       o_mul_multiplicand;
    logic [N-1:0]       o_mul_multiplier;
    logic               i_mul_finished;
    logic [2*N-1:0]     i_mul_product;

    modport master (
        input  i_valid, i_multiplicand, i_multiplier, i_ready,
        input  i_mul_finished, i_mul_product,
        output o_ready, o_valid, o_product, o_error,
        output o_mul_start, o_mul_multiplicand, o_mul_multiplier
    );

    modport slave (
        output i_valid, i_multiplicand, i_multiplier, i_ready,
        output i_mul_finished, i_mul_product,
        input  o_ready, o_valid, o_product, o_error,
        input  o_mul_start, o_mul_multiplicand, o_mul_multiplier
    );
endinterface

// File: rtl/multiply_controller.sv
// Handshaking front end for the sequential shift-add multiplier: accepts an
// operand pair, pulses start, waits for the finished strobe (with timeout),
// then holds the 2N-bit product behind a valid/ready output.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-high reset
//   bus      multiply_controller_if.master (operand, result and multiplier buses)
// Build option: MULTIPLY_CONTROLLER_SIGNED_EN selects two's complement operands
// (magnitudes sent to the multiplier, product sign-corrected on capture).
module multiply_controller #(
    parameter int unsigned N = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    multiply_controller_if.master   bus
);
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(N + 3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic            start_q, start_d;
    logic [PW-1:0]   product_q, product_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
    logic            sign_q, sign_d;
`endif

    // State and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            product_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            start_q   <= start_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
            sign_q    <= sign_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
        sign_d    = sign_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && ready_q) begin
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
                    // -2^(N-1) negates to itself, which reads correctly as unsigned
                    mcand_d  = bus.i_multiplicand[N-1] ? N'(-bus.i_multiplicand)
                                                       : bus.i_multiplicand;
                    mplier_d = bus.i_multiplier[N-1] ? N'(-bus.i_multiplier)
                                                     : bus.i_multiplier;
                    sign_d   = bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
`else
                    mcand_d  = bus.i_multiplicand;
                    mplier_d = bus.i_multiplier;
`endif
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_mul_finished) begin
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
                    product_d = sign_q ? PW'(-bus.i_mul_product) : bus.i_mul_product;
`else
                    product_d = bus.i_mul_product;
`endif
                    state_d   = ST_DONE;
                end else if (cnt_q == CW'(N + 1)) begin
                    // Counter would reach N+2 on this edge: abandon the operation
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered decodes of the next state
        ready_d = (state_d == ST_IDLE);
        start_d = (state_d == ST_START);
        valid_d = (state_d == ST_DONE);
    end

    assign bus.o_ready            = ready_q;
    assign bus.o_valid            = valid_q;
    assign bus.o_product          = product_q;
    assign bus.o_error            = error_q;
    assign bus.o_mul_start        = start_q;
    assign bus.o_mul_multiplicand = mcand_q;
    assign bus.o_mul_multiplier   = mplier_q;
endmodule

// File: tb/tb_multiply_controller.sv
// Scoreboard bench for multiply_controller: stimulus pushes expected products,
// a monitor pops and compares on every o_valid/i_ready handshake, and a
// behavioural multiplier answers each start pulse N-1 edges after it is sampled.
module tb_multiply_controller;
    localparam int unsigned N  = 8;
    localparam int unsigned PW = 2 * N;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc;
    } exp_t;

    logic clk;
    logic rst;
    multiply_controller_if #(.N(N)) bus ();

    multiply_controller #(.N(N)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   gen    = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic suppress = 1'b0;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: the arithmetic product of the operands as the build interprets them
    function automatic logic [PW-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        longint pa, pb;
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
        pa = longint'($signed(a));
        pb = longint'($signed(b));
`else
        pa = longint'(a);
        pb = longint'(b);
`endif
        return PW'(pa * pb);
    endfunction

    // Operand value the multiplier should see
    function automatic logic [N-1:0] mag(input logic [N-1:0] a);
`ifdef MULTIPLY_CONTROLLER_SIGNED_EN
        longint v;
        v = longint'($signed(a));
        if (v < 0) v = -v;
        return N'(v);
`else
        return a;
`endif
    endfunction

    // i_ready driver
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b0;
                1:       bus.i_ready = 1'b1;
                default: bus.i_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Behavioural multiplier: samples start at E1, finished high after edge E1+N-1
    initial begin
        logic [PW-1:0] wa, wb;
        int g;
        bus.i_mul_finished = 1'b0;
        bus.i_mul_product  = '0;
        forever begin
            @(negedge clk);
            if (bus.o_mul_start && !suppress && !rst) begin
                g  = gen;
                wa = PW'(bus.o_mul_multiplicand);
                wb = PW'(bus.o_mul_multiplier);
                repeat (N) @(posedge clk);
                #1;
                if (g == gen) begin
                    bus.i_mul_finished = 1'b1;
                    bus.i_mul_product  = PW'(wa * wb);
                    @(posedge clk);
                    #1;
                    bus.i_mul_finished = 1'b0;
                    bus.i_mul_product  = '0;
                end
            end
        end
    end

    // Start pulse must last exactly one cycle
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_mul_start) chk("start_one_cycle", 64'(prev_start), 64'(0));
            prev_start = bus.o_mul_start;
        end
    end

    // Monitor: result latency, value, stability and pop on handshake
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 64'(bus.o_valid), 64'(0));
                end else begin
                    if (!prev_valid) chk("valid_latency", 64'(cyc), 64'(q[0].acc + int'(N) + 1));
                    chk("product", 64'(bus.o_product), 64'(q[0].prod));
                    if (bus.i_ready) void'(q.pop_front());
                end
            end
            prev_valid = bus.o_valid;
        end
    end

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic push);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_ready && n < 200);
        if (!bus.o_ready) begin
            chk("ready_wait_expired", 64'(bus.o_ready), 64'(1));
            return;
        end
        bus.i_valid        = 1'b1;
        bus.i_multiplicand = a;
        bus.i_multiplier   = b;
        if (push) q.push_back('{prod: model(a, b), acc: cyc + 1});
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'(0));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.o_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_valid) chk("valid_wait_expired", 64'(bus.o_valid), 64'(1));
    endtask

    task automatic reset_async();
        @(posedge clk);
        #2;
        rst = 1'b1;
        gen++;
        q.delete();
        #1;
        chk("reset_flags", 64'({bus.o_ready, bus.o_valid, bus.o_error, bus.o_mul_start}), 64'(4'b1000));
        chk("reset_product", 64'(bus.o_product), 64'(0));
        chk("reset_operands", 64'({bus.o_mul_multiplicand, bus.o_mul_multiplier}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.o_ready), 64'(1));
        repeat (N + 4) @(posedge clk);
    endtask

    initial begin
        int   acc;
        logic to;
        logic [N-1:0] pa, pb;
        rst                = 1'b1;
        bus.i_valid        = 1'b0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;

        // Power-on reset
        @(negedge clk);
        chk("init_flags", 64'({bus.o_ready, bus.o_valid, bus.o_error, bus.o_mul_start}), 64'(4'b1000));
        chk("init_product", 64'(bus.o_product), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("init_ready", 64'(bus.o_ready), 64'(1));

        // Directed operands, including width and sign extremes
        do_op(8'd13, 8'd11, 1'b1);
        do_op(8'd255, 8'd255, 1'b1);
        do_op(8'hFD, 8'd5, 1'b1);
        do_op(8'h80, 8'h80, 1'b1);
        do_op(8'h80, 8'd1, 1'b1);
        do_op(8'd0, 8'd77, 1'b1);
        drain();

        // Random operands with random consumer back-pressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) do_op(N'($urandom()), N'($urandom()), 1'b1);
        drain();
        ready_mode = 1;

        // Sustained back-pressure with a pending operand held on the input
        ready_mode = 0;
        repeat (2) @(posedge clk);
        do_op(8'd21, 8'd3, 1'b1);
        wait_valid();
        pa = 8'd200;
        pb = 8'd6;
        bus.i_valid        = 1'b1;
        bus.i_multiplicand = pa;
        bus.i_multiplier   = pb;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(bus.o_ready), 64'(0));
            chk("bp_valid_held", 64'(bus.o_valid), 64'(1));
        end
        chk("bp_operand_held", 64'(bus.o_mul_multiplicand), 64'(mag(8'd21)));
        ready_mode = 1;
        q.push_back('{prod: model(pa, pb), acc: cyc + 3});
        @(negedge clk);
        chk("bp_ready_before_release", 64'(bus.o_ready), 64'(0));
        @(negedge clk);
        chk("bp_idle_after_take", 64'({bus.o_ready, bus.o_valid}), 64'(2'b10));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        drain();
        chk("bp_pending_operand", 64'(bus.o_mul_multiplicand), 64'(mag(pa)));

        // Timeout: multiplier never answers
        suppress = 1'b1;
        do_op(8'd9, 8'd9, 1'b0);
        acc = cyc;
        for (int k = 0; k <= int'(N) + 3; k++) begin
            @(negedge clk);
            to = (cyc >= acc + int'(N) + 3);
            chk("timeout_error", 64'(bus.o_error), 64'(to));
            chk("timeout_ready", 64'(bus.o_ready), 64'(to));
            chk("timeout_no_valid", 64'(bus.o_valid), 64'(0));
        end
        suppress = 1'b0;
        do_op(8'd2, 8'd3, 1'b1);
        drain();
        chk("error_sticky", 64'(bus.o_error), 64'(1));
        reset_async();

        // Reset during WAIT, then a clean operation
        do_op(8'd3, 8'd4, 1'b1);
        repeat (3) @(negedge clk);
        reset_async();
        do_op(8'd7, 8'd9, 1'b1);
        drain();

        // Reset while a result is pending in DONE
        ready_mode = 0;
        repeat (2) @(posedge clk);
        do_op(8'd5, 8'd6, 1'b1);
        wait_valid();
        reset_async();
        ready_mode = 1;
        do_op(8'd7, 8'd9, 1'b1);
        drain();

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/multiply_controller.md
# multiply_controller

Handshaking front end for the team's sequential shift-add multiplier. Accepts operand pairs over a valid/ready interface and drives the multiplier's start pulse and operand buses. Waits for the multiplier's finished strobe, then captures and holds the 2N-bit product behind a valid/ready output until the consumer takes it. Sits directly upstream of the multiplier, and is the only agent that issues start to it.

## Interface
Parameters:
- N, 8, operand width; product width is 2N; N ≥ 2.

Ports:
- i_clock  in  1  system clock, rising-edge.
- i_reset  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- i_valid  in  1  operand pair present.
- o_ready  out  1  controller can accept an operand pair.
- i_multiplicand  in  N  operand A.
- i_multiplier  in  N  operand B.
- o_valid  out  1  o_product holds a completed result.
- i_ready  in  1  consumer takes the result.
- o_product  out  2N  registered result.
- o_error  out  1  sticky timeout flag; cleared only by reset.
- o_mul_start  out  1  start pulse to the multiplier.
- o_mul_multiplicand  out  N  registered operand A to the multiplier.
- o_mul_multiplier  out  N  registered operand B to the multiplier.
- i_mul_finished  in  1  multiplier finished strobe (one cycle).
- i_mul_product  in  2N  multiplier product, valid while i_mul_finished is high.

## Operation
FSM with four states: IDLE, START, WAIT and DONE.
- **IDLE:** o_ready = 1.
  - On i_valid & o_ready: register the operands onto o_mul_* and go to START.
- **START:** o_mul_start = 1 for exactly one cycle.
  - Clear the wait counter and go to WAIT.
- **WAIT:** o_mul_start = 0. The counter increments each cycle.
  - On i_mul_finished: register i_mul_product (sign-corrected, see Configuration) into o_product, set o_valid and go to DONE.
  - If the counter reaches N+2 without i_mul_finished: set o_error, discard the operation and go to IDLE.
- **DONE:** o_valid = 1. o_product is held stable.
  - On i_ready: clear o_valid and go to IDLE.
- o_mul_multiplicand and o_mul_multiplier are held stable from the accept edge until the next accept.
- o_ready is 0 in START, WAIT and DONE. There is no overlap, so at most one operation is in flight.
- i_mul_finished outside WAIT is ignored.
- The width rule is N × N → 2N; the product never overflows.

## Timing
- Reset values: state IDLE, o_ready 1, o_valid 0, o_product 0, o_error 0, o_mul_start 0, o_mul_* operands 0.
- o_mul_start is high during the cycle after the accept edge. The multiplier samples it at the next edge (E1).
- The multiplier asserts i_mul_finished N−1 edges after E1.
- o_valid rises N+1 edges after the accept edge (9 for N=8).
- Minimum issue interval: N+3 edges with i_ready held high.
- Back-pressure: o_valid and o_product are held indefinitely while i_ready = 0. No new operand is accepted.
- A timeout sets o_error and returns to IDLE at the edge where the counter hits N+2. o_valid never asserts for that operation.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values, including a pending o_valid (the result is lost).
  - i_reset must also drive the multiplier's synchronous reset and be held for at least one rising edge.

## Configuration
- **MULTIPLY_CONTROLLER_SIGNED_EN defined:**
  - Operands are two's complement.
  - On accept, the controller registers the magnitudes |A| and |B| onto o_mul_* and stores sign = A[N−1] ^ B[N−1].
  - On capture, o_product = sign ? −i_mul_product : i_mul_product (2N-bit two's complement).
  - −2^(N−1) has magnitude 2^(N−1), which fits unsigned in N bits.
- **Undefined:**
  - Operands pass through unchanged; the result is unsigned; no sign logic is built.

## Test plan
- **Reset:** assert i_reset asynchronously mid-cycle → all outputs at reset values immediately; o_ready = 1 after release.
- **Unsigned, N=8:** 13 × 11 → o_product = 0x008F, o_valid exactly 9 edges after accept; o_mul_start high for exactly one cycle. Also 255 × 255 → 0xFE01.
- **Back-pressure:** i_ready = 0 for 20 cycles after o_valid → o_product stable, o_ready = 0, a held i_valid is not accepted. Raise i_ready → IDLE next edge, then the pending operand is accepted.
- **Signed build:**
  - −3 × 5 → 0xFFF1.
  - −128 × −128 → 0x4000.
  - −128 × 1 → 0xFF80.
- **Timeout:** the bench suppresses i_mul_finished → o_error = 1 at N+2 counter cycles after entering WAIT, state returns to IDLE, o_valid stays 0, o_error stays set until reset.
- **Reset mid-WAIT and mid-DONE:** the controller returns to IDLE, and the next operation 7 × 9 returns 0x003F with no stale result.
